// File: rtl/dmem_responder.sv
// dmem_responder: memory side of the processor's data-memory port.
// Word-addressed RAM that is swept to zero after every reset, returns
// registered read data one cycle after each request (write-first on stores)
// and raises a sticky flag on any access outside the implemented range.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic                  ready,
    output logic                  addr_err
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // INIT sweeps the RAM to zero; RUN serves one access per cycle.
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;

    // One bit wider than the index: the MSB sets once the last word is cleared.
    logic [ADDR_WIDTH:0]     counter;
    logic [ADDR_WIDTH:0]     counter_next;

    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   index;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic [DATA_WIDTH-1:0]   q_next;
    logic                    err_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Any set bit above the implemented index width is an out-of-range access.
    assign in_range  = (address_dmem[31:ADDR_WIDTH] == '0);
    assign index     = address_dmem[ADDR_WIDTH-1:0];
    assign mem_rdata = mem[index];

    // Ready is a decode of the registered state, so it drops with reset at once.
    assign ready = (state == ST_RUN);

    // Next-state, sweep counter, RAM write port and output-register inputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        counter_next = counter;
        mem_we       = 1'b0;
        mem_waddr    = index;
        mem_wdata    = data;
        q_next       = q_dmem;
        err_next     = addr_err;

        case (state)
            ST_INIT: begin
                // The sweep owns the write port; processor requests are ignored.
                mem_we       = 1'b1;
                mem_waddr    = counter[ADDR_WIDTH-1:0];
                mem_wdata    = '0;
                counter_next = counter + CNT_ONE;
                q_next       = '0;
                if (counter_next[ADDR_WIDTH]) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!in_range) begin
                    // Never alias onto a real word: no write, zero data, flag it.
                    q_next   = '0;
                    err_next = 1'b1;
                end else if (wren) begin
                    // Write-first: the stored word is also the returned word.
                    mem_we = 1'b1;
                    q_next = data;
                end else begin
                    q_next = mem_rdata;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // State, sweep counter, read-data register and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state    <= ST_INIT;
            counter  <= '0;
            q_dmem   <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            counter  <= counter_next;
            q_dmem   <= q_next;
            addr_err <= err_next;
        end
    end

    // Single write port shared by the clear sweep and processor stores.
    always_ff @(posedge clock) begin
        // NOTE: the RAM has no reset; the INIT sweep is what zeroes it after every reset.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a 16-word RAM.
module tb_dmem_responder;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic [31:0]   address_dmem;
    logic [DW-1:0] data;
    logic          wren;
    logic [DW-1:0] q_dmem;
    logic          ready;
    logic          addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ready        (ready),
        .addr_err     (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_q;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        wren         = w;
        address_dmem = a;
        data         = d;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].wren, vecs[i].addr, vecs[i].data);
            step();
            check({vecs[i].name, " q"},     q_dmem,          vecs[i].exp_q);
            check({vecs[i].name, " err"},   {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, " ready"}, {31'b0, ready},  32'd1);
        end
    endtask

    // Sweep of 16 edges: nothing accepted, ready rises exactly on edge 16.
    task automatic check_sweep(input string tag);
        for (int e = 1; e <= 16; e++) begin
            step();
            check({tag, " sweep q"},   q_dmem,            32'h0);
            check({tag, " sweep err"}, {31'b0, addr_err}, 32'h0);
            check({tag, " sweep ready"}, {31'b0, ready}, (e == 16) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{"wr5",      1'b1, 32'd5,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{"rd5",      1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{"rd6",      1'b0, 32'd6,        32'h0,        32'h0,        1'b0};
        vecs[3] = '{"wr6",      1'b1, 32'd6,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{"rd6b",     1'b0, 32'd6,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[5] = '{"oor_wr16", 1'b1, 32'd16,       32'h12345678, 32'h0,        1'b1};
        vecs[6] = '{"rd0",      1'b0, 32'd0,        32'h0,        32'h0,        1'b1};
        vecs[7] = '{"oor_wr_hi",1'b1, 32'h80000003, 32'h00000001, 32'h0,        1'b1};
        vecs[8] = '{"oor_rd",   1'b0, 32'h00000100, 32'h0,        32'h0,        1'b1};
        vecs[9] = '{"rd3",      1'b0, 32'd3,        32'h0,        32'd9,        1'b1};

        // Reset held low for three edges while stores are driven.
        reset = 1'b0;
        drive(1'b1, 32'd20, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst q",     q_dmem,            32'h0);
            check("rst ready", {31'b0, ready},    32'h0);
            check("rst err",   {31'b0, addr_err}, 32'h0);
        end
        reset = 1'b1;
        check_sweep("init");

        // Every word reads zero after the sweep.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'(i), 32'hFFFFFFFF);
            step();
            check("clear rd", q_dmem, 32'h0);
        end

        run_vecs(0, 4);

        // Back-to-back: store i*3 to every word, then read back descending.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 32'(i * 3));
            step();
            check("b2b wr", q_dmem, 32'(i * 3));
        end
        for (int i = 15; i >= 0; i--) begin
            drive(1'b0, 32'(i), 32'h0);
            step();
            check("b2b rd", q_dmem, 32'(i * 3));
        end

        run_vecs(5, 9);

        // Sticky error survives ten in-range accesses.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 32'(i), 32'h0);
            step();
            check("sticky q",   q_dmem,            32'(i * 3));
            check("sticky err", {31'b0, addr_err}, 32'h1);
        end

        // Asynchronous reset pulse between edges.
        drive(1'b1, 32'd3, 32'hA5A5A5A5);
        step();
        check("wr3 q", q_dmem, 32'hA5A5A5A5);
        drive(1'b0, 32'd3, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async q",     q_dmem,            32'h0);
        check("async ready", {31'b0, ready},    32'h0);
        check("async err",   {31'b0, addr_err}, 32'h0);
        reset = 1'b1;
        check_sweep("mid");

        drive(1'b0, 32'd3, 32'h0);
        step();
        check("post rd3", q_dmem, 32'h0);
        drive(1'b0, 32'd5, 32'h0);
        step();
        check("post rd5", q_dmem, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
